// File: rtl/mips_isa.sv
// mips_isa: shared MIPS encodings for the fetch/decode slice.
//   Opcode constants (R_TYPE, J, JAL, BEQ, BNE) and the JR/JALR funct values.
//   fetch_state_t : FSM state of instr_fetch (FETCH, VALID).
//   branch_offset : sign-extended, word-scaled branch displacement.
package mips_isa;

   localparam logic [5:0] OP_R_TYPE  = 6'b000000;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;

   localparam logic [5:0] FUNCT_JR   = 6'b001000;
   localparam logic [5:0] FUNCT_JALR = 6'b001001;

   typedef enum logic {
      FETCH = 1'b0,
      VALID = 1'b1
   } fetch_state_t;

   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory read bus (req/ack handshake).
//   imem_req   : read request, driven by the fetch unit
//   imem_addr  : word-aligned read address
//   imem_ack   : read data valid, only meaningful while imem_req=1
//   imem_rdata : instruction word, valid with imem_ack
// Modports: master = fetch unit, slave = instruction memory.
interface instr_fetch_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC selection for the presented instruction.
//   pc_plus4  : sequential successor of the presented pc
//   instr     : presented instruction
//   jump/branch/zero : decoder and ALU qualifiers
//   jr_target : register value for JR/JALR
//   next_pc   : selected successor (first match: J/JAL, JR/JALR, taken branch, pc_plus4)
//   taken     : 1 when next_pc comes from a redirect rather than pc_plus4
module next_pc_calc
   import mips_isa::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [31:0] instr,
   input  logic        jump,
   input  logic        branch,
   input  logic        zero,
   input  logic [31:0] jr_target,
   output logic [31:0] next_pc,
   output logic        taken
);

   logic [5:0] op;

   assign op = instr[31:26];

   always_comb begin
      next_pc = pc_plus4;
      taken   = 1'b0;
      if (jump && (op == OP_J || op == OP_JAL)) begin
         next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
         taken   = 1'b1;
      end else if (jump && op == OP_R_TYPE) begin
         next_pc = jr_target;
         taken   = 1'b1;
      end else if (branch && ((op == OP_BEQ && zero) || (op == OP_BNE && !zero))) begin
         next_pc = pc_plus4 + branch_offset(instr[15:0]);
         taken   = 1'b1;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: program counter, instruction-memory fetch and single
// instruction register feeding the control decoder.
//   RESET_PC    : pc loaded on reset
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   imem        : instruction memory bus (master side)
//   stall       : downstream hold, presented instruction not consumed
//   jump/branch/zero/jr_target : control/ALU inputs for the presented instruction
//   instr, opcode, funct, instr_valid : presented instruction to decode
//   pc, pc_plus4 : address of the presented instruction and its successor
// Build option: INSTR_FETCH_DELAY_SLOT_EN enables a MIPS branch delay slot.
module instr_fetch
   import mips_isa::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   instr_fetch_if.master      imem,
   input  logic               stall,
   input  logic               jump,
   input  logic               branch,
   input  logic               zero,
   input  logic [31:0]        jr_target,
   output logic [31:0]        instr,
   output logic [5:0]         opcode,
   output logic [5:0]         funct,
   output logic               instr_valid,
   output logic [31:0]        pc,
   output logic [31:0]        pc_plus4
);

   fetch_state_t state_q, state_d;
   logic         load_instr;
   logic         consume;
   logic [31:0]  next_pc;
   logic         taken;

   assign pc_plus4       = pc + 32'd4;
   assign opcode         = instr[31:26];
   assign funct          = instr[5:0];
   assign imem.imem_addr = pc;

   next_pc_calc u_next_pc (
      .pc_plus4  (pc_plus4),
      .instr     (instr),
      .jump      (jump),
      .branch    (branch),
      .zero      (zero),
      .jr_target (jr_target),
      .next_pc   (next_pc),
      .taken     (taken)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      imem.imem_req = 1'b0;
      instr_valid   = 1'b0;
      load_instr    = 1'b0;
      consume       = 1'b0;
      case (state_q)
         FETCH: begin
            // Request is masked during reset so nothing is issued while held.
            imem.imem_req = !reset;
            if (imem.imem_ack) begin
               load_instr = 1'b1;
               state_d    = VALID;
            end
         end
         VALID: begin
            instr_valid = 1'b1;
            if (!stall) begin
               consume = 1'b1;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

`ifdef INSTR_FETCH_DELAY_SLOT_EN
   logic [31:0] pending_q;
   logic        in_slot_q;

   // A taken redirect parks its target; the slot instruction at pc_plus4 runs
   // first, and any redirect it asks for is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc        <= RESET_PC;
         instr     <= '0;
         pending_q <= '0;
         in_slot_q <= 1'b0;
      end else begin
         if (load_instr) instr <= imem.imem_rdata;
         if (consume) begin
            if (in_slot_q) begin
               pc        <= pending_q;
               in_slot_q <= 1'b0;
            end else begin
               pc <= pc_plus4;
               if (taken) begin
                  pending_q <= next_pc;
                  in_slot_q <= 1'b1;
               end
            end
         end
      end
   end
`else
   logic unused_taken;
   assign unused_taken = taken;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc    <= RESET_PC;
         instr <= '0;
      end else begin
         if (load_instr) instr <= imem.imem_rdata;
         if (consume)    pc    <= next_pc;
      end
   end
`endif

endmodule
